// File: rtl/aes_seq_pkg.sv
// Shared types and defaults for the AES-128 round sequencer.
// Contents: FSM state enum, default round count and index width.
package aes_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    KLOAD,
    KGEN,
    READY,
    LOAD,
    RND,
    OUT
  } state_e;

  localparam int unsigned NUM_ROUNDS_DEFAULT = 10;
  localparam int unsigned RND_W_DEFAULT      = 4;

endpackage

// File: rtl/aes_seq_round_ctr.sv
// Loadable round/key index counter, shared by key expansion and round stepping.
// Ports:
//   clk, n_rst   clock, asynchronous active-low reset
//   clr_i        force count to 0 (highest priority)
//   load_i       load load_val_i
//   inc_i        increment by one
//   load_val_i   value used by load_i
//   cnt_o        current count
//   tc_o         count equals NUM_ROUNDS
module aes_seq_round_ctr
  import aes_seq_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = NUM_ROUNDS_DEFAULT,
  parameter int unsigned RND_W      = RND_W_DEFAULT
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic             inc_i,
  input  logic [RND_W-1:0] load_val_i,
  output logic [RND_W-1:0] cnt_o,
  output logic             tc_o
);

  logic [RND_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (inc_i) begin
      cnt_d = cnt_q + RND_W'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == RND_W'(NUM_ROUNDS));

endmodule

// File: rtl/aes_round_sequencer.sv
// Control FSM for the iterative AES-128 datapath: key load, on-the-fly
// round-key expansion, block capture, round stepping and output hand-off.
// Optional feature macro: AES_SEQ_BLOCK_COUNT_EN adds blocks_done.
// Ports:
//   clk, n_rst      clock, asynchronous active-low reset
//   key_received    level, new key on the key bus (rising edge = key event)
//   data_ready      plaintext valid
//   fifo_full       output FIFO cannot accept a word
//   key_load        capture key bus into round key 0
//   key_gen_en      compute round key key_idx
//   key_idx         round-key write index during expansion
//   data_taken      plaintext captured, initial AddRoundKey applied
//   round_en        perform round round_idx
//   round_idx       current round / round-key read index
//   final_round     last round (no MixColumns)
//   data_out_load   push ciphertext to the FIFO
//   key_valid       all round keys valid
//   busy            FSM not in IDLE or READY
//   blocks_done     (AES_SEQ_BLOCK_COUNT_EN only) completed block count
module aes_round_sequencer
  import aes_seq_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = NUM_ROUNDS_DEFAULT,
  parameter int unsigned RND_W      = RND_W_DEFAULT
`ifdef AES_SEQ_BLOCK_COUNT_EN
  ,
  parameter int unsigned CNT_W      = 16
`endif
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             key_received,
  input  logic             data_ready,
  input  logic             fifo_full,
  output logic             key_load,
  output logic             key_gen_en,
  output logic [RND_W-1:0] key_idx,
  output logic             data_taken,
  output logic             round_en,
  output logic [RND_W-1:0] round_idx,
  output logic             final_round,
  output logic             data_out_load,
  output logic             key_valid,
  output logic             busy
`ifdef AES_SEQ_BLOCK_COUNT_EN
  ,
  output logic [CNT_W-1:0] blocks_done
`endif
);

  state_e           state_q, state_d;
  logic             key_received_q;
  logic             pend_q, pend_d;
  logic             key_valid_q, key_valid_d;
  logic             dol_q, dol_d;
  logic             cnt_clr, cnt_load, cnt_inc, cnt_tc;
  logic [RND_W-1:0] cnt;
  logic             key_rise;

  assign key_rise = key_received & ~key_received_q;

  aes_seq_round_ctr #(
    .NUM_ROUNDS (NUM_ROUNDS),
    .RND_W      (RND_W)
  ) u_ctr (
    .clk        (clk),
    .n_rst      (n_rst),
    .clr_i      (cnt_clr),
    .load_i     (cnt_load),
    .inc_i      (cnt_inc),
    .load_val_i (RND_W'(1)),
    .cnt_o      (cnt),
    .tc_o       (cnt_tc)
  );

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    key_valid_d = key_valid_q;
    dol_d       = 1'b0;
    cnt_clr     = 1'b0;
    cnt_load    = 1'b0;
    cnt_inc     = 1'b0;
    case (state_q)
      IDLE: begin
        if (key_rise) state_d = KLOAD;
      end
      KLOAD: begin
        state_d  = KGEN;
        cnt_load = 1'b1;
      end
      KGEN: begin
        // A fresh key mid-expansion restarts expansion from the new key.
        if (key_rise) begin
          state_d = KLOAD;
          cnt_clr = 1'b1;
        end else if (cnt_tc) begin
          state_d     = READY;
          cnt_clr     = 1'b1;
          key_valid_d = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      READY: begin
        if (key_rise) state_d = KLOAD;
        else if (data_ready) state_d = LOAD;
      end
      LOAD: begin
        if (key_rise) pend_d = 1'b1;
        state_d  = RND;
        cnt_load = 1'b1;
      end
      RND: begin
        if (key_rise) pend_d = 1'b1;
        if (cnt_tc) begin
          state_d = OUT;
          // Decide the push on entry so data_out_load stays a register.
          dol_d   = ~fifo_full;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      OUT: begin
        if (key_rise) pend_d = 1'b1;
        if (dol_q) begin
          // Pushed this cycle: leave OUT; a pending rekey skips READY.
          cnt_clr = 1'b1;
          if (pend_q || key_rise) begin
            state_d = KLOAD;
            pend_d  = 1'b0;
          end else begin
            state_d = READY;
          end
        end else if (!fifo_full) begin
          dol_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d == KLOAD) key_valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q        <= IDLE;
      key_received_q <= 1'b0;
      pend_q         <= 1'b0;
      key_valid_q    <= 1'b0;
      dol_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      key_received_q <= key_received;
      pend_q         <= pend_d;
      key_valid_q    <= key_valid_d;
      dol_q          <= dol_d;
    end
  end

  // Counter is zero outside KGEN/RND/OUT, so one register serves both indices.
  assign key_load      = (state_q == KLOAD);
  assign key_gen_en    = (state_q == KGEN);
  assign data_taken    = (state_q == LOAD);
  assign round_en      = (state_q == RND);
  assign final_round   = round_en & cnt_tc;
  assign key_idx       = key_gen_en ? cnt : '0;
  assign round_idx     = key_gen_en ? '0 : cnt;
  assign data_out_load = dol_q;
  assign key_valid     = key_valid_q;
  assign busy          = (state_q != IDLE) && (state_q != READY);

`ifdef AES_SEQ_BLOCK_COUNT_EN
  logic [CNT_W-1:0] blocks_done_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      blocks_done_q <= '0;
    end else if (state_q == KLOAD) begin
      blocks_done_q <= '0;
    end else if (dol_q) begin
      blocks_done_q <= blocks_done_q + CNT_W'(1);
    end
  end

  assign blocks_done = blocks_done_q;
`endif

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed self-checking bench for aes_round_sequencer.
// Optional feature macro: AES_SEQ_BLOCK_COUNT_EN enables blocks_done checks.
module tb_aes_round_sequencer;

  localparam int unsigned NR = 10;
  localparam int unsigned RW = 4;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          key_received;
  logic          data_ready;
  logic          fifo_full;
  logic          key_load;
  logic          key_gen_en;
  logic [RW-1:0] key_idx;
  logic          data_taken;
  logic          round_en;
  logic [RW-1:0] round_idx;
  logic          final_round;
  logic          data_out_load;
  logic          key_valid;
  logic          busy;
`ifdef AES_SEQ_BLOCK_COUNT_EN
  logic [15:0]   blocks_done;
`endif

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  aes_round_sequencer #(
    .NUM_ROUNDS (NR),
    .RND_W      (RW)
  ) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .key_received  (key_received),
    .data_ready    (data_ready),
    .fifo_full     (fifo_full),
    .key_load      (key_load),
    .key_gen_en    (key_gen_en),
    .key_idx       (key_idx),
    .data_taken    (data_taken),
    .round_en      (round_en),
    .round_idx     (round_idx),
    .final_round   (final_round),
    .data_out_load (data_out_load),
    .key_valid     (key_valid),
    .busy          (busy)
`ifdef AES_SEQ_BLOCK_COUNT_EN
    ,
    .blocks_done   (blocks_done)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] all_outs();
    return {key_load, key_gen_en, key_idx, data_taken, round_en, round_idx,
            final_round, data_out_load, key_valid, busy};
  endfunction

  // One block from READY with the FIFO free: full timing check.
  task automatic run_block();
    data_ready = 1'b1;
    tick();
    check_eq("blk_taken", 32'(data_taken), 1);
    data_ready = 1'b0;
    for (int unsigned r = 1; r <= NR; r++) begin
      tick();
      check_eq("blk_round_en", 32'(round_en), 1);
      check_eq("blk_round_idx", 32'(round_idx), 32'(r));
      check_eq("blk_final", 32'(final_round), (r == NR) ? 1 : 0);
      check_eq("blk_no_early_out", 32'({data_out_load, data_taken}), 0);
    end
    tick();
    check_eq("blk_out_load", 32'(data_out_load), 1);
    check_eq("blk_round_en_off", 32'(round_en), 0);
    tick();
    check_eq("blk_out_pulse", 32'(data_out_load), 0);
    check_eq("blk_idle_busy", 32'(busy), 0);
    check_eq("blk_round_idx0", 32'(round_idx), 0);
  endtask

  task automatic expand_key();
    tick();
    check_eq("kl_pulse", 32'(key_load), 1);
    check_eq("kl_valid_clr", 32'(key_valid), 0);
    check_eq("kl_busy", 32'(busy), 1);
    for (int unsigned k = 1; k <= NR; k++) begin
      tick();
      check_eq("kg_en", 32'(key_gen_en), 1);
      check_eq("kg_idx", 32'(key_idx), 32'(k));
      check_eq("kg_no_load", 32'({key_load, data_taken}), 0);
    end
    tick();
    check_eq("key_valid", 32'(key_valid), 1);
    check_eq("kg_done", 32'({key_gen_en, key_idx}), 0);
    check_eq("ready_busy", 32'(busy), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_rst        = 1'b0;
    key_received = 1'b0;
    data_ready   = 1'b0;
    fifo_full    = 1'b0;
    #3;
    check_eq("reset_outs", 32'(all_outs()), 0);
    tick();
    tick();
    n_rst = 1'b1;

    // No key: data_ready must be ignored.
    data_ready = 1'b1;
    for (int unsigned i = 0; i < 100; i++) begin
      tick();
      check_eq("nokey_quiet", 32'({data_taken, data_out_load, busy}), 0);
    end
    data_ready = 1'b0;

    // Key held high: one load, ten expansions, no second load.
    key_received = 1'b1;
    expand_key();
    for (int unsigned i = 0; i < 20; i++) begin
      tick();
      check_eq("held_no_reload", 32'(key_load), 0);
    end

    // Single block, FIFO free.
    run_block();

    // FIFO full at the last round: hold in OUT for five cycles.
    data_ready = 1'b1;
    tick();
    check_eq("ff_taken", 32'(data_taken), 1);
    data_ready = 1'b0;
    for (int unsigned r = 1; r <= NR; r++) tick();
    check_eq("ff_final", 32'(final_round), 1);
    fifo_full = 1'b1;
    for (int unsigned j = 0; j < 5; j++) begin
      tick();
      check_eq("ff_hold_noload", 32'(data_out_load), 0);
      check_eq("ff_hold_busy", 32'(busy), 1);
    end
    fifo_full = 1'b0;
    tick();
    check_eq("ff_release_load", 32'(data_out_load), 1);
    tick();
    check_eq("ff_back_ready", 32'({data_out_load, busy}), 0);

    // Rekey at round 4 with data_ready held throughout.
    key_received = 1'b0;
    tick();
    tick();
    data_ready = 1'b1;
    tick();
    check_eq("rk_taken", 32'(data_taken), 1);
    for (int unsigned r = 1; r <= 4; r++) begin
      tick();
      check_eq("rk_round_idx", 32'(round_idx), 32'(r));
    end
    key_received = 1'b1;
    for (int unsigned r = 5; r <= NR; r++) begin
      tick();
      check_eq("rk_round_cont", 32'(round_idx), 32'(r));
      check_eq("rk_round_en", 32'(round_en), 1);
    end
    tick();
    check_eq("rk_block_done", 32'(data_out_load), 1);
    tick();
    check_eq("rk_key_load", 32'(key_load), 1);
    check_eq("rk_no_taken", 32'(data_taken), 0);
    check_eq("rk_valid_clr", 32'(key_valid), 0);
    for (int unsigned k = 1; k <= NR; k++) begin
      tick();
      check_eq("rk_kgen_idx", 32'(key_idx), 32'(k));
      check_eq("rk_kgen_no_taken", 32'(data_taken), 0);
    end
    tick();
    check_eq("rk_valid_back", 32'(key_valid), 1);
    check_eq("rk_ready_no_taken", 32'(data_taken), 0);
    tick();
    check_eq("rk_taken_after", 32'(data_taken), 1);
    data_ready = 1'b0;
    for (int unsigned r = 1; r <= NR; r++) tick();
    tick();
    check_eq("rk_second_block", 32'(data_out_load), 1);
    tick();

    // Asynchronous reset at round 6.
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    for (int unsigned r = 1; r <= 6; r++) tick();
    check_eq("ar_round6", 32'(round_idx), 6);
    n_rst = 1'b0;
    #1;
    check_eq("ar_outs_zero", 32'(all_outs()), 0);
    key_received = 1'b0;
    tick();
    tick();
    n_rst = 1'b1;
    data_ready = 1'b1;
    for (int unsigned i = 0; i < 20; i++) begin
      tick();
      check_eq("ar_ignored", 32'({data_taken, busy, key_valid}), 0);
    end
    data_ready = 1'b0;

    // New key then eight blocks.
    key_received = 1'b1;
    expand_key();
`ifdef AES_SEQ_BLOCK_COUNT_EN
    check_eq("cnt_start", 32'(blocks_done), 0);
`endif
    for (int unsigned b = 0; b < 8; b++) run_block();
`ifdef AES_SEQ_BLOCK_COUNT_EN
    check_eq("cnt_eight", 32'(blocks_done), 8);
`endif

    // Simultaneous key_rise and data_ready in READY: rekey wins.
    key_received = 1'b0;
    tick();
    key_received = 1'b1;
    data_ready   = 1'b1;
    tick();
    check_eq("sim_key_load", 32'(key_load), 1);
    check_eq("sim_no_taken", 32'(data_taken), 0);
    for (int unsigned k = 1; k <= NR; k++) tick();
    check_eq("sim_kgen_last", 32'(key_idx), 32'(NR));
    tick();
    check_eq("sim_valid", 32'(key_valid), 1);
`ifdef AES_SEQ_BLOCK_COUNT_EN
    check_eq("cnt_cleared", 32'(blocks_done), 0);
`endif
    tick();
    check_eq("sim_taken", 32'(data_taken), 1);
    data_ready = 1'b0;
    for (int unsigned r = 1; r <= NR; r++) tick();
    tick();
    check_eq("sim_block_out", 32'(data_out_load), 1);
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
